// File: rtl/dm_burst_fill_responder.sv
`timescale 1ns/1ps
// dm_burst_fill_responder
// Memory-side responder for cache line fills. A single request names the missing (critical) word.
// The block then reads BURST_LEN words from DataMemory one at a time. It starts at the critical
// word and wraps within the aligned block. Each word is handed to the cache over a valid/ready
// fill channel before the next read is issued.
//
// Ports
//   clk, rst              : clock (rising edge), asynchronous active-low reset
//   req_valid/ready/addr  : line-fill request; ready only while idle, requests are never queued
//   mem_rd/addr/rdata     : one-cycle read strobe; rdata is valid MEM_LAT cycles after mem_rd
//   fill_valid/ready      : fill word handshake toward the cache
//   fill_addr/data/last   : current fill word, its address, and end-of-burst marker
//
// Every output is either a flop or a decode of the state register. There is no combinational
// path from an input to an output.
module dm_burst_fill_responder #(
   parameter int unsigned ADDR_W    = 15,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned MEM_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fill_valid,
   input  logic              fill_ready,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_last
);

   localparam int unsigned      OFF_W    = $clog2(BURST_LEN);
   localparam int unsigned      LAT_W    = $clog2(MEM_LAT + 1);
   localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(BURST_LEN - 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StSend} state_e;

   state_e                   state_q, state_d;
   logic [ADDR_W-OFF_W-1:0]  base_q, base_d;
   logic [OFF_W-1:0]         off0_q, off0_d;
   logic [OFF_W-1:0]         cnt_q, cnt_d;
   logic [OFF_W-1:0]         cnt_inc, off_next;
   logic [LAT_W-1:0]         lat_q, lat_d;
   logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0]        fill_addr_q, fill_addr_d;
   logic [DATA_W-1:0]        fill_data_q, fill_data_d;
   logic                     fill_valid_q, fill_valid_d;
   logic                     fill_last_q, fill_last_d;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_valid) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (lat_q == LAT_ONE) state_d = StSend;
         StSend:  if (fill_ready) state_d = fill_last_q ? StIdle : StIssue;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state
   always_comb begin
      base_d       = base_q;
      off0_d       = off0_q;
      cnt_d        = cnt_q;
      lat_d        = lat_q;
      mem_addr_d   = mem_addr_q;
      fill_addr_d  = fill_addr_q;
      fill_data_d  = fill_data_q;
      fill_valid_d = fill_valid_q;
      fill_last_d  = fill_last_q;
      // Offset arithmetic is OFF_W wide, so it wraps inside the block and never carries into base.
      cnt_inc      = cnt_q + OFF_W'(1);
      off_next     = off0_q + cnt_inc;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               base_d     = req_addr[ADDR_W-1:OFF_W];
               off0_d     = req_addr[OFF_W-1:0];
               cnt_d      = '0;
               mem_addr_d = req_addr;
            end
         end
         StIssue: lat_d = LAT_INIT;
         StWait: begin
            lat_d = lat_q - LAT_ONE;
            // The last wait cycle is the one in which mem_rdata is valid.
            if (lat_q == LAT_ONE) begin
               fill_data_d  = mem_rdata;
               fill_addr_d  = mem_addr_q;
               fill_valid_d = 1'b1;
               fill_last_d  = (cnt_q == LAST_CNT);
            end
         end
         StSend: begin
            if (fill_ready) begin
               fill_valid_d = 1'b0;
               fill_last_d  = 1'b0;
               if (!fill_last_q) begin
                  cnt_d      = cnt_inc;
                  // Load the next read address now so it is stable throughout the issue cycle.
                  mem_addr_d = {base_q, off_next};
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q       <= '0;
         off0_q       <= '0;
         cnt_q        <= '0;
         lat_q        <= '0;
         mem_addr_q   <= '0;
         fill_addr_q  <= '0;
         fill_data_q  <= '0;
         fill_valid_q <= 1'b0;
         fill_last_q  <= 1'b0;
      end else begin
         base_q       <= base_d;
         off0_q       <= off0_d;
         cnt_q        <= cnt_d;
         lat_q        <= lat_d;
         mem_addr_q   <= mem_addr_d;
         fill_addr_q  <= fill_addr_d;
         fill_data_q  <= fill_data_d;
         fill_valid_q <= fill_valid_d;
         fill_last_q  <= fill_last_d;
      end
   end

   // Outputs: state decodes and registered values only
   always_comb begin
      req_ready  = (state_q == StIdle);
      mem_rd     = (state_q == StIssue);
      mem_addr   = mem_addr_q;
      fill_valid = fill_valid_q;
      fill_addr  = fill_addr_q;
      fill_data  = fill_data_q;
      fill_last  = fill_last_q;
   end

endmodule

// File: tb/tb_dm_burst_fill_responder.sv
`timescale 1ns/1ps
// Bench for dm_burst_fill_responder. Two instances are used: MEM_LAT=1 (dut1) and MEM_LAT=3 (dut3).
// A shared random memory image backs both instances. The expected burst is computed from the
// address rules with plain arithmetic.
module tb_dm_burst_fill_responder;
   localparam int unsigned AW = 15;
   localparam int unsigned DW = 32;
   localparam int unsigned BL = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // dut1 (MEM_LAT=1)
   logic          req_valid = 1'b0, req_ready, mem_rd, fill_valid, fill_last;
   logic          fill_ready = 1'b0;
   logic [AW-1:0] req_addr = '0, mem_addr, fill_addr;
   logic [DW-1:0] mem_rdata, fill_data;

   // dut3 (MEM_LAT=3)
   logic          req_valid3 = 1'b0, req_ready3, mem_rd3, fill_valid3, fill_last3;
   logic          fill_ready3 = 1'b0;
   logic [AW-1:0] req_addr3 = '0, mem_addr3, fill_addr3;
   logic [DW-1:0] mem_rdata3, fill_data3;

   dm_burst_fill_responder #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .fill_valid(fill_valid),
      .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_data(fill_data),
      .fill_last(fill_last)
   );

   dm_burst_fill_responder #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_addr(req_addr3), .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
      .fill_valid(fill_valid3), .fill_ready(fill_ready3), .fill_addr(fill_addr3),
      .fill_data(fill_data3), .fill_last(fill_last3)
   );

   // Memory models: data valid exactly MEM_LAT cycles after the strobe, junk otherwise.
   logic          p1_v = 1'b0;
   logic [AW-1:0] p1_a = '0;
   always @(posedge clk) begin
      p1_v <= mem_rd;
      p1_a <= mem_addr;
   end
   assign mem_rdata = p1_v ? mem[p1_a] : (32'hBAD0_0000 ^ 32'(cyc));

   logic [2:0]    p3_v = '0;
   logic [AW-1:0] p3_a0 = '0, p3_a1 = '0, p3_a2 = '0;
   always @(posedge clk) begin
      p3_v  <= {p3_v[1:0], mem_rd3};
      p3_a0 <= mem_addr3;
      p3_a1 <= p3_a0;
      p3_a2 <= p3_a1;
   end
   assign mem_rdata3 = p3_v[2] ? mem[p3_a2] : (32'h0DD0_0000 ^ 32'(cyc));

   // Event logs (observation only)
   int            acc_log[$], rd_cyc_log[$], fv_log[$], rr_log[$], hs_cyc_log[$];
   logic [AW-1:0] rd_addr_log[$], hs_addr_log[$];
   logic [DW-1:0] hs_data_log[$];
   logic          hs_last_log[$];
   int            drops = 0;
   logic          fv_prev = 1'b0, hs_prev = 1'b0, rr_prev = 1'b1;

   always @(negedge clk) begin
      if (rst) begin
         if (req_valid && req_ready) acc_log.push_back(cyc);
         if (mem_rd) begin
            rd_addr_log.push_back(mem_addr);
            rd_cyc_log.push_back(cyc);
         end
         if (fill_valid && !fv_prev) fv_log.push_back(cyc);
         if (req_ready && !rr_prev) rr_log.push_back(cyc);
         if (fv_prev && !fill_valid && !hs_prev) drops++;
         if (fill_valid && fill_ready) begin
            hs_addr_log.push_back(fill_addr);
            hs_data_log.push_back(fill_data);
            hs_last_log.push_back(fill_last);
            hs_cyc_log.push_back(cyc);
         end
         fv_prev = fill_valid;
         hs_prev = fill_valid && fill_ready;
         rr_prev = req_ready;
      end else begin
         fv_prev = 1'b0;
         hs_prev = 1'b0;
         rr_prev = 1'b1;
      end
   end

   int            acc3_log[$], fv3_log[$], hs3_cyc_log[$];
   logic [AW-1:0] hs3_addr_log[$];
   logic [DW-1:0] hs3_data_log[$];
   logic          hs3_last_log[$];
   logic          fv3_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         if (req_valid3 && req_ready3) acc3_log.push_back(cyc);
         if (fill_valid3 && !fv3_prev) fv3_log.push_back(cyc);
         if (fill_valid3 && fill_ready3) begin
            hs3_addr_log.push_back(fill_addr3);
            hs3_data_log.push_back(fill_data3);
            hs3_last_log.push_back(fill_last3);
            hs3_cyc_log.push_back(cyc);
         end
         fv3_prev = fill_valid3;
      end else begin
         fv3_prev = 1'b0;
      end
   end

   // Reference: i-th word of a burst starting at critical address a.
   function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input int i);
      int base;
      int off;
      base = int'(a) / int'(BL) * int'(BL);
      off  = (int'(a) % int'(BL) + i) % int'(BL);
      return AW'(base + off);
   endfunction

   function automatic int at_i(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1000;
   endfunction

   task automatic clear_logs();
      acc_log.delete(); rd_cyc_log.delete(); fv_log.delete(); rr_log.delete();
      hs_cyc_log.delete(); rd_addr_log.delete(); hs_addr_log.delete();
      hs_data_log.delete(); hs_last_log.delete();
      acc3_log.delete(); fv3_log.delete(); hs3_cyc_log.delete(); hs3_addr_log.delete();
      hs3_data_log.delete(); hs3_last_log.delete();
   endtask

   task automatic send_req(input logic [AW-1:0] a);
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_addr  = a;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_beats(input int n, input string name);
      int budget = 300;
      while (hs_addr_log.size() < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (hs_addr_log.size() < n) begin
         errors++;
         $display("FAIL %s timeout: beats=%0d required=%0d", name, hs_addr_log.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, mem_rd, mem_addr, fill_valid, fill_addr, fill_data, fill_last} !==
          {1'b1, 1'b0, 15'h0, 1'b0, 15'h0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset dut1: rr=%b rd=%b ma=%h fv=%b fa=%h fd=%h fl=%b, required 1 0 0 0 0 0 0",
                  req_ready, mem_rd, mem_addr, fill_valid, fill_addr, fill_data, fill_last);
      end
      checks++;
      if ({req_ready3, mem_rd3, mem_addr3, fill_valid3, fill_last3} !==
          {1'b1, 1'b0, 15'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset dut3: rr=%b rd=%b ma=%h fv=%b fl=%b, required 1 0 0 0 0",
                  req_ready3, mem_rd3, mem_addr3, fill_valid3, fill_last3);
      end
      #2 rst = 1'b1;
   endtask

   task automatic test_aligned();
      logic [AW-1:0] ea;
      clear_logs();
      fill_ready = 1'b1;
      send_req(15'h0100);
      wait_beats(BL, "aligned");
      @(negedge clk);
      for (int i = 0; i < int'(BL); i++) begin
         ea = exp_addr(15'h0100, i);
         checks++;
         if (i >= rd_addr_log.size() || rd_addr_log[i] !== ea) begin
            errors++;
            $display("FAIL aligned mem_addr[%0d]: got %h, required %h", i,
                     (i < rd_addr_log.size()) ? rd_addr_log[i] : 'x, ea);
         end
         checks++;
         if (i >= hs_addr_log.size() ||
             {hs_addr_log[i], hs_data_log[i], hs_last_log[i]} !== {ea, mem[ea], i == int'(BL) - 1}) begin
            errors++;
            $display("FAIL aligned beat[%0d]: beat wrong or missing, required addr=%h data=%h last=%b",
                     i, ea, mem[ea], i == int'(BL) - 1);
         end
      end
      checks++;
      if (at_i(fv_log, 0) - at_i(acc_log, 0) != 3) begin
         errors++;
         $display("FAIL aligned first fill_valid: got T+%0d, required T+3",
                  at_i(fv_log, 0) - at_i(acc_log, 0));
      end
      checks++;
      if (at_i(rr_log, 0) != at_i(hs_cyc_log, 3) + 1) begin
         errors++;
         $display("FAIL aligned req_ready return: got cycle %0d, required %0d", at_i(rr_log, 0),
                  at_i(hs_cyc_log, 3) + 1);
      end
      checks++;
      if (at_i(hs_cyc_log, 3) - at_i(acc_log, 0) != 12) begin
         errors++;
         $display("FAIL aligned burst length: got %0d, required 12",
                  at_i(hs_cyc_log, 3) - at_i(acc_log, 0));
      end
   endtask

   task automatic test_wrap_random();
      logic [AW-1:0] addrs[8];
      logic [AW-1:0] ea;
      int budget;
      addrs[0] = 15'h7FFE;
      addrs[1] = 15'h0003;
      for (int b = 2; b < 8; b++) addrs[b] = AW'($urandom);
      for (int b = 0; b < 8; b++) begin
         clear_logs();
         fill_ready = 1'b1;
         send_req(addrs[b]);
         budget = 300;
         while (hs_addr_log.size() < int'(BL) && budget > 0) begin
            @(posedge clk); #1;
            fill_ready = (b < 2) ? 1'b1 : (($urandom % 3) != 0);
            budget--;
         end
         fill_ready = 1'b1;
         @(negedge clk);
         for (int i = 0; i < int'(BL); i++) begin
            ea = exp_addr(addrs[b], i);
            checks++;
            if (i >= rd_addr_log.size() || rd_addr_log[i] !== ea) begin
               errors++;
               $display("FAIL wrap %h mem_addr[%0d]: wrong or missing, required %h", addrs[b], i, ea);
            end
            checks++;
            if (i >= hs_addr_log.size() ||
                {hs_addr_log[i], hs_data_log[i], hs_last_log[i]} !== {ea, mem[ea], i == int'(BL) - 1}) begin
               errors++;
               $display("FAIL wrap %h beat[%0d]: wrong or missing, required addr=%h data=%h",
                        addrs[b], i, ea, mem[ea]);
            end
         end
      end
      checks++;
      if (drops != 0) begin
         errors++;
         $display("FAIL fill_valid drop without handshake: got %0d, required 0", drops);
      end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] ea;
      logic [AW+DW+1:0] snap = '0;
      int stall = 0;
      int budget = 300;
      clear_logs();
      fill_ready = 1'b1;
      send_req(15'h1235);
      while (hs_addr_log.size() < int'(BL) && budget > 0) begin
         @(posedge clk); #1;
         budget--;
         if (fill_valid && hs_addr_log.size() == 2 && stall < 5) begin
            if (stall == 0) snap = {fill_valid, fill_addr, fill_data, fill_last};
            else begin
               checks++;
               if ({fill_valid, fill_addr, fill_data, fill_last} !== snap) begin
                  errors++;
                  $display("FAIL stall hold %0d: got %h, required %h", stall,
                           {fill_valid, fill_addr, fill_data, fill_last}, snap);
               end
            end
            checks++;
            if (mem_rd !== 1'b0) begin
               errors++;
               $display("FAIL stall mem_rd: got %b, required 0", mem_rd);
            end
            fill_ready = 1'b0;
            stall++;
         end else begin
            fill_ready = 1'b1;
         end
      end
      fill_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < int'(BL); i++) begin
         ea = exp_addr(15'h1235, i);
         checks++;
         if (i >= hs_addr_log.size() ||
             {hs_addr_log[i], hs_data_log[i], hs_last_log[i]} !== {ea, mem[ea], i == int'(BL) - 1}) begin
            errors++;
            $display("FAIL stall beat[%0d]: wrong or missing, required addr=%h data=%h", i, ea, mem[ea]);
         end
      end
      checks++;
      if (at_i(hs_cyc_log, 2) - at_i(fv_log, 2) != 5) begin
         errors++;
         $display("FAIL stall length: got %0d, required 5", at_i(hs_cyc_log, 2) - at_i(fv_log, 2));
      end
      checks++;
      if (at_i(rd_cyc_log, 3) != at_i(hs_cyc_log, 2) + 1) begin
         errors++;
         $display("FAIL stall next mem_rd: got cycle %0d, required %0d", at_i(rd_cyc_log, 3),
                  at_i(hs_cyc_log, 2) + 1);
      end
   endtask

   task automatic test_busy();
      logic [AW-1:0] ea;
      clear_logs();
      fill_ready = 1'b1;
      send_req(15'h0155);
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_addr  = 15'h0200;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy req_ready: got %b, required 0", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_beats(BL, "busy");
      @(negedge clk);
      checks++;
      if (acc_log.size() != 1) begin
         errors++;
         $display("FAIL busy accepts: got %0d, required 1", acc_log.size());
      end
      for (int i = 0; i < int'(BL); i++) begin
         ea = exp_addr(15'h0155, i);
         checks++;
         if (i >= hs_addr_log.size() || i >= rd_addr_log.size() || rd_addr_log[i] !== ea ||
             {hs_addr_log[i], hs_data_log[i], hs_last_log[i]} !== {ea, mem[ea], i == int'(BL) - 1}) begin
            errors++;
            $display("FAIL busy beat[%0d]: wrong or missing, required addr=%h data=%h", i, ea, mem[ea]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] ea;
      int budget = 100;
      clear_logs();
      fill_ready = 1'b1;
      send_req(15'h0123);
      while (rd_addr_log.size() < 2 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({fill_valid, mem_rd, req_ready} !== 3'b001) begin
         errors++;
         $display("FAIL reset mid-burst: got fv=%b rd=%b rr=%b, required 0 0 1",
                  fill_valid, mem_rd, req_ready);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({fill_valid, mem_rd, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset held: got fv=%b rd=%b rr=%b, required 0 0 1",
                     fill_valid, mem_rd, req_ready);
         end
      end
      #2 rst = 1'b1;
      clear_logs();
      send_req(15'h0040);
      wait_beats(BL, "post-reset");
      @(negedge clk);
      checks++;
      if (rd_addr_log.size() != int'(BL)) begin
         errors++;
         $display("FAIL post-reset reads: got %0d, required %0d", rd_addr_log.size(), BL);
      end
      for (int i = 0; i < int'(BL); i++) begin
         ea = exp_addr(15'h0040, i);
         checks++;
         if (i >= hs_addr_log.size() ||
             {hs_addr_log[i], hs_data_log[i], hs_last_log[i]} !== {ea, mem[ea], i == int'(BL) - 1}) begin
            errors++;
            $display("FAIL post-reset beat[%0d]: wrong or missing, required addr=%h data=%h",
                     i, ea, mem[ea]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] ea;
      int budget = 300;
      clear_logs();
      fill_ready3 = 1'b1;
      @(posedge clk); #1;
      req_valid3 = 1'b1;
      req_addr3  = 15'h0010;
      while (acc3_log.size() < 1 && budget > 0) begin @(negedge clk); budget--; end
      @(posedge clk); #1;
      req_addr3 = 15'h0020;
      while (acc3_log.size() < 2 && budget > 0) begin @(negedge clk); budget--; end
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      while (hs3_addr_log.size() < 2 * int'(BL) && budget > 0) begin @(negedge clk); budget--; end
      checks++;
      if (acc3_log.size() != 2 || hs3_addr_log.size() != 2 * int'(BL)) begin
         errors++;
         $display("FAIL b2b counts: accepts=%0d beats=%0d, required 2 and %0d",
                  acc3_log.size(), hs3_addr_log.size(), 2 * BL);
      end
      checks++;
      if (at_i(acc3_log, 1) != at_i(hs3_cyc_log, 3) + 1) begin
         errors++;
         $display("FAIL b2b second accept: got cycle %0d, required %0d", at_i(acc3_log, 1),
                  at_i(hs3_cyc_log, 3) + 1);
      end
      checks++;
      if (at_i(fv3_log, 0) - at_i(acc3_log, 0) != 5) begin
         errors++;
         $display("FAIL b2b first fill latency: got %0d, required 5",
                  at_i(fv3_log, 0) - at_i(acc3_log, 0));
      end
      checks++;
      if (at_i(fv3_log, 4) - at_i(acc3_log, 1) != 5) begin
         errors++;
         $display("FAIL b2b second fill latency: got %0d, required 5",
                  at_i(fv3_log, 4) - at_i(acc3_log, 1));
      end
      checks++;
      if (at_i(hs3_cyc_log, 3) - at_i(acc3_log, 0) != 20) begin
         errors++;
         $display("FAIL b2b burst length: got %0d, required 20",
                  at_i(hs3_cyc_log, 3) - at_i(acc3_log, 0));
      end
      for (int i = 0; i < 2 * int'(BL); i++) begin
         ea = exp_addr((i < int'(BL)) ? 15'h0010 : 15'h0020, i % int'(BL));
         checks++;
         if (i >= hs3_addr_log.size() ||
             {hs3_addr_log[i], hs3_data_log[i], hs3_last_log[i]} !==
             {ea, mem[ea], (i % int'(BL)) == int'(BL) - 1}) begin
            errors++;
            $display("FAIL b2b beat[%0d]: wrong or missing, required addr=%h data=%h", i, ea, mem[ea]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      test_reset();
      test_aligned();
      test_wrap_random();
      test_backpressure();
      test_busy();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
